// File: rtl/bind_probe_monitor_pkg.sv
// rtl/bind_probe_monitor_pkg.sv - shared state encoding and probe index constants
package bind_probe_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [1:0] PRB_NONE = 2'd0;
  localparam logic [1:0] PRB_P1   = 2'd1;
  localparam logic [1:0] PRB_P2   = 2'd2;
  localparam logic [1:0] PRB_P3   = 2'd3;

endpackage

// File: rtl/bind_probe_monitor_sat_add_cnt.sv
// rtl/bind_probe_monitor_sat_add_cnt.sv - saturating accumulator with clear and 2-bit increment
module sat_add_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W:0] sum;

  // One extra bit catches the carry so the count pins at all-ones.
  assign sum = {1'b0, cnt} + (CNT_W+1)'(inc);

  always_ff @(posedge clk) begin
    if (!reset_l || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/bind_probe_monitor.sv
// rtl/bind_probe_monitor.sv - windowed compare of three bound probes with sticky verdict
module bind_probe_monitor
  import bind_probe_monitor_pkg::*;
#(
  parameter int          WIDTH         = 8,
  parameter int unsigned EXP1          = 32'h04,
  parameter int unsigned EXP2          = 32'h05,
  parameter int unsigned EXP3          = 32'h06,
  parameter int          SETTLE_CYCLES = 2,
  parameter int          CHECK_CYCLES  = 4,
  parameter int          TIMEOUT       = 16,
  parameter int          CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic             valid,
  input  logic [WIDTH-1:0] p1,
  input  logic [WIDTH-1:0] p2,
  input  logic [WIDTH-1:0] p3,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       first_err_idx,
  output logic [WIDTH-1:0] first_err_val,
  output logic [CNT_W-1:0] first_err_sample
);

  localparam logic [WIDTH-1:0] E1 = WIDTH'(EXP1);
  localparam logic [WIDTH-1:0] E2 = WIDTH'(EXP2);
  localparam logic [WIDTH-1:0] E3 = WIDTH'(EXP3);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  sample_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              m1, m2, m3;
  logic [1:0]        n_miss;
  logic              start_ok;
  logic              chk;

  always_comb begin
    m1       = (p1 != E1);
    m2       = (p2 != E2);
    m3       = (p3 != E3);
    n_miss   = {1'b0, m1} + {1'b0, m2} + {1'b0, m3};
    start_ok = start && (state == ST_IDLE || state == ST_DONE);
    chk      = (state == ST_CHECK) && valid;
  end

  sat_add_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk     (clk),
    .reset_l (reset_l),
    .clr     (start_ok),
    .en      (chk),
    .inc     (n_miss),
    .cnt     (err_count)
  );

  // busy/done/pass decode only registered state, never live inputs.
  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == '0) && !timeout;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state            <= ST_IDLE;
      settle_cnt       <= '0;
      sample_cnt       <= '0;
      idle_cnt         <= '0;
      timeout          <= 1'b0;
      first_err_idx    <= PRB_NONE;
      first_err_val    <= '0;
      first_err_sample <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state            <= ST_SETTLE;
            settle_cnt       <= '0;
            sample_cnt       <= '0;
            idle_cnt         <= '0;
            timeout          <= 1'b0;
            first_err_idx    <= PRB_NONE;
            first_err_val    <= '0;
            first_err_sample <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            state      <= ST_CHECK;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        ST_CHECK: begin
          if (valid) begin
            idle_cnt   <= '0;
            sample_cnt <= sample_cnt + CNT_W'(1);
            // Lowest probe index wins when several miss in one sample.
            if (first_err_idx == PRB_NONE && n_miss != 2'd0) begin
              first_err_sample <= sample_cnt;
              if (m1) begin
                first_err_idx <= PRB_P1;
                first_err_val <= p1;
              end else if (m2) begin
                first_err_idx <= PRB_P2;
                first_err_val <= p2;
              end else begin
                first_err_idx <= PRB_P3;
                first_err_val <= p3;
              end
            end
            if (sample_cnt == CNT_W'(CHECK_CYCLES - 1)) begin
              state <= ST_DONE;
            end
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
            if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
              state   <= ST_DONE;
              timeout <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
